// File: rtl/icache_pkg.sv
// Shared types and width helpers for the instruction-cache line-fill engine.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } fill_state_e;

    // Word-index bits inside a line.
    function automatic int offset_bits(input int num_blocks);
        return $clog2(num_blocks);
    endfunction

    // Byte-index bits inside a word.
    function automatic int byte_bits(input int block_size);
        return $clog2(block_size);
    endfunction

    // Total line width in bits.
    function automatic int line_w(input int num_blocks, input int block_size);
        return 8 * block_size * num_blocks;
    endfunction

    localparam int DEF_LINE_W = 8 * 4 * 4;

endpackage

// File: rtl/icache_line_buf.sv
// One-entry line buffer: holds the most recently filled line and its base,
// and flags a hit when a new request lands in the same line.
module icache_line_buf
    import icache_pkg::*;
#(
    parameter int NUM_BLOCKS = 4,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [31:0]                            lookup_base,
    output logic                                   hit,
    output logic [line_w(NUM_BLOCKS,BLOCK_SIZE)-1:0] rd_line,
    input  logic                                   wr_en,
    input  logic [31:0]                            wr_base,
    input  logic [line_w(NUM_BLOCKS,BLOCK_SIZE)-1:0] wr_line
);

    localparam int LW = line_w(NUM_BLOCKS, BLOCK_SIZE);
    localparam int LB = offset_bits(NUM_BLOCKS) + byte_bits(BLOCK_SIZE);

    logic          vld_q;
    logic [31-LB:0] tag_q;
    logic [LW-1:0] data_q;

    logic unused_lo;
    assign unused_lo = &{1'b0, lookup_base[LB-1:0], wr_base[LB-1:0]};

    // Entry storage; only the valid bit needs a reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else if (wr_en) begin
            vld_q  <= 1'b1;
            tag_q  <= wr_base[31:LB];
            data_q <= wr_line;
        end
    end

    assign hit     = vld_q && (tag_q == lookup_base[31:LB]);
    assign rd_line = data_q;

endmodule

// File: rtl/icache_line_fill.sv
// Line-fill engine: turns one cache-line request into NUM_BLOCKS sequential
// word reads on the memory bus and returns the assembled line with a
// one-cycle ready pulse. Optional one-entry line buffer under
// ICACHE_LINE_FILL_BUF_EN short-circuits repeat requests to the same line.
module icache_line_fill
    import icache_pkg::*;
#(
    parameter int NUM_BLOCKS = 4,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     line_req_valid,
    output logic                                     line_req_ready,
    input  logic [31:0]                              line_req_addr,
    output logic [line_w(NUM_BLOCKS,BLOCK_SIZE)-1:0] line_req_rdata,
    output logic                                     mem_valid,
    input  logic                                     mem_ready,
    output logic [31:0]                              mem_addr,
    input  logic [8*BLOCK_SIZE-1:0]                  mem_rdata
);

    localparam int WW = 8 * BLOCK_SIZE;
    localparam int LW = line_w(NUM_BLOCKS, BLOCK_SIZE);
    localparam int CW = offset_bits(NUM_BLOCKS);
    localparam int LB = offset_bits(NUM_BLOCKS) + byte_bits(BLOCK_SIZE);

    fill_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d, abort_now;
    logic          mem_valid_q, mem_valid_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          ready_q, ready_d;
    logic [LW-1:0] fill_q, fill_d, fill_tmp;
    logic [LW-1:0] line_q, line_d;
    logic          fill_last;
    logic [31:0]   req_base;

    assign req_base = {line_req_addr[31:LB], {LB{1'b0}}};

    logic unused_addr;
    assign unused_addr = &{1'b0, line_req_addr[LB-1:0]};

`ifdef ICACHE_LINE_FILL_BUF_EN
    logic [31:0]   base_q, base_d;
    logic          buf_hit;
    logic [LW-1:0] buf_line;

    icache_line_buf #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .lookup_base (req_base),
        .hit         (buf_hit),
        .rd_line     (buf_line),
        .wr_en       (fill_last),
        .wr_base     (base_q),
        .wr_line     (fill_tmp)
    );
`else
    logic unused_fill;
    assign unused_fill = fill_last;
`endif

    // Next-state and next-output logic; every register has a *_d here.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        fill_d      = fill_q;
        fill_tmp    = fill_q;
        line_d      = line_q;
        ready_d     = 1'b0;
        fill_last   = 1'b0;
        abort_now   = abort_q | ~line_req_valid;
`ifdef ICACHE_LINE_FILL_BUF_EN
        base_d      = base_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (line_req_valid) begin
                    cnt_d   = '0;
                    abort_d = 1'b0;
`ifdef ICACHE_LINE_FILL_BUF_EN
                    base_d  = req_base;
                    if (buf_hit) begin
                        line_d  = buf_line;
                        ready_d = 1'b1;
                        state_d = RESP;
                    end else
`endif
                    begin
                        mem_addr_d  = req_base;
                        mem_valid_d = 1'b1;
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                // Once the requester lets go we remember it, but the word in
                // flight must still complete before the bus is released.
                abort_d = abort_now;
                if (mem_valid_q && mem_ready) begin
                    if (abort_now) begin
                        mem_valid_d = 1'b0;
                        abort_d     = 1'b0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        fill_tmp[int'(cnt_q)*WW +: WW] = mem_rdata;
                        fill_d     = fill_tmp;
                        cnt_d      = cnt_q + CW'(1);
                        mem_addr_d = mem_addr_q + 32'(BLOCK_SIZE);
                        if (cnt_q == CW'(NUM_BLOCKS - 1)) begin
                            fill_last   = 1'b1;
                            line_d      = fill_tmp;
                            ready_d     = 1'b1;
                            mem_valid_d = 1'b0;
                            state_d     = RESP;
                        end
                    end
                end
            end
            RESP:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            ready_q     <= 1'b0;
            fill_q      <= '0;
            line_q      <= '0;
`ifdef ICACHE_LINE_FILL_BUF_EN
            base_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            ready_q     <= ready_d;
            fill_q      <= fill_d;
            line_q      <= line_d;
`ifdef ICACHE_LINE_FILL_BUF_EN
            base_q      <= base_d;
`endif
        end
    end

    assign line_req_ready = ready_q;
    assign line_req_rdata = line_q;
    assign mem_valid      = mem_valid_q;
    assign mem_addr       = mem_addr_q;

endmodule

// File: tb/tb_icache_line_fill.sv
// Bench for icache_line_fill: memory model with programmable wait states,
// scoreboard queues for expected bus addresses and returned lines.
module tb_icache_line_fill;

    localparam int NB = 4;
    localparam int BS = 4;
    localparam int WW = 8 * BS;
    localparam int LW = WW * NB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          line_req_valid = 1'b0;
    logic          line_req_ready;
    logic [31:0]   line_req_addr = '0;
    logic [LW-1:0] line_req_rdata;
    logic          mem_valid;
    logic          mem_ready = 1'b0;
    logic [31:0]   mem_addr;
    logic [WW-1:0] mem_rdata = '0;

    icache_line_fill #(.NUM_BLOCKS(NB), .BLOCK_SIZE(BS)) dut (
        .clk            (clk),
        .reset          (reset),
        .line_req_valid (line_req_valid),
        .line_req_ready (line_req_ready),
        .line_req_addr  (line_req_addr),
        .line_req_rdata (line_req_rdata),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0]   addr_q[$];
    logic [LW-1:0] line_q[$];
    logic [31:0]   salt = 32'h0;
    int            wait_n = 0;
    int            wcnt = 0;
    int            cyc = 0;
    int            req_cyc = 0;
    int            pulses = 0;
    int            pulse_cyc = 0;
    int            mv_cnt = 0;

    always @(posedge clk) cyc++;

    // Memory: mem_ready after wait_n idle cycles per word, data = addr ^ salt.
    always @(posedge clk) begin
        #1;
        if (mem_valid) begin
            if (wcnt >= wait_n) begin
                mem_ready = 1'b1;
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
            mem_rdata = mem_addr ^ salt;
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    // Monitor: check bus addresses and returned lines against the scoreboard.
    always @(negedge clk) begin
        logic [31:0]   ea;
        logic [LW-1:0] el;
        if (mem_valid) mv_cnt++;
        if (mem_valid && mem_ready) begin
            ea = (addr_q.size() > 0) ? addr_q.pop_front() : ~mem_addr;
            chk("mem_addr", LW'(mem_addr), LW'(ea));
        end else if (mem_valid) begin
            ea = (addr_q.size() > 0) ? addr_q[0] : ~mem_addr;
            chk("addr_stable", LW'(mem_addr), LW'(ea));
        end
        if (line_req_ready) begin
            pulses++;
            pulse_cyc = cyc - req_cyc;
            el = (line_q.size() > 0) ? line_q.pop_front() : ~line_req_rdata;
            chk("rdata", line_req_rdata, el);
        end
    end

    function automatic logic [LW-1:0] mk_line(input logic [31:0] base, input logic [31:0] s);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < NB; i++) l[i*WW +: WW] = (base + 32'(i*BS)) ^ s;
        return l;
    endfunction

    // One request/response. hit=1 means the line must come from the buffer.
    task automatic fill(input logic [31:0] a, input int w, input int exp_cyc,
                        input logic [31:0] s, input bit hit);
        logic [31:0] base;
        int p0, mv0, t;
        base = a & ~32'(NB*BS-1);
        wait_n = w;
        salt = hit ? ~s : s;
        if (!hit) for (int i = 0; i < NB; i++) addr_q.push_back(base + 32'(i*BS));
        line_q.push_back(mk_line(base, s));
        p0 = pulses;
        mv0 = mv_cnt;
        @(posedge clk); #1;
        line_req_addr = a;
        line_req_valid = 1'b1;
        req_cyc = cyc;
        t = 0;
        while (pulses == p0 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        chk("pulse_seen", LW'(pulses), LW'(p0 + 1));
        chk("pulse_cyc", LW'(pulse_cyc), LW'(exp_cyc));
        // Requester keeps valid through DONE, which must be ignored.
        @(posedge clk);
        @(posedge clk); #1;
        line_req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("one_pulse", LW'(pulses), LW'(p0 + 1));
        chk("idle_mv", LW'(mem_valid), LW'(0));
        chk("addr_q_empty", LW'(addr_q.size()), LW'(0));
        if (hit) chk("no_mem", LW'(mv_cnt), LW'(mv0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", LW'(line_req_ready), LW'(0));
        chk("rst_mv", LW'(mem_valid), LW'(0));
        chk("rst_addr", LW'(mem_addr), LW'(0));
        chk("rst_rdata", line_req_rdata, LW'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Zero-wait fill and 2-wait fill
        fill(32'h0000_1234, 0, 5, 32'hA5A5_0000, 1'b0);
        fill(32'h0000_3008, 2, 13, 32'h5A00_1111, 1'b0);

        // Abort: valid drops during the third word's cycle
        wait_n = 0;
        salt = 32'h1357_9BDF;
        for (int i = 0; i < 3; i++) addr_q.push_back(32'h4000 + 32'(i*BS));
        p0 = pulses;
        @(posedge clk); #1;
        line_req_addr = 32'h4000;
        line_req_valid = 1'b1;
        req_cyc = cyc;
        repeat (3) @(posedge clk); #1;
        line_req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_mv", LW'(mem_valid), LW'(0));
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_nopulse", LW'(pulses), LW'(p0));
        chk("abort_q_empty", LW'(addr_q.size()), LW'(0));
        fill(32'h0000_4000, 0, 5, 32'h2468_ACE0, 1'b0);

        // Reset during the third word's wait
        wait_n = 2;
        salt = 32'h0F0F_0F0F;
        for (int i = 0; i < 3; i++) addr_q.push_back(32'h5000 + 32'(i*BS));
        p0 = pulses;
        @(posedge clk); #1;
        line_req_addr = 32'h5000;
        line_req_valid = 1'b1;
        req_cyc = cyc;
        repeat (7) @(posedge clk); #1;
        reset = 1'b1;
        line_req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_mv", LW'(mem_valid), LW'(0));
        chk("mrst_addr", LW'(mem_addr), LW'(0));
        chk("mrst_ready", LW'(line_req_ready), LW'(0));
        chk("mrst_rdata", line_req_rdata, LW'(0));
        chk("mrst_q", LW'(addr_q.size()), LW'(1));
        addr_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mrst_nopulse", LW'(pulses), LW'(p0));
        fill(32'h0000_6004, 0, 5, 32'h7777_0001, 1'b0);

        // Top-of-memory line: no wrap into the next line
        fill(32'hFFFF_FFF4, 0, 5, 32'h0000_BEEF, 1'b0);

`ifdef ICACHE_LINE_FILL_BUF_EN
        fill(32'h0000_1230, 0, 5, 32'hC0DE_0000, 1'b0);
        fill(32'h0000_1238, 0, 1, 32'hC0DE_0000, 1'b1);
        fill(32'h0000_2000, 0, 5, 32'h9999_0000, 1'b0);
`endif

        chk("line_q_empty", LW'(line_q.size()), LW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_line_fill.md
# icache_line_fill

Line-fill engine between the wide instruction cache's miss port and the 32-bit main-memory bus. Accepts one line request, issues NUM_BLOCKS sequential word reads, assembles the words into one line, and returns it with a single-cycle ready pulse. Sits directly upstream of the cache; the cache's mem_req_* port connects to this block's line_req_* port.

## Interface
- NUM_BLOCKS, 4, words per line; power of two, ≥2
- BLOCK_SIZE, 4, bytes per word; memory word width is 8*BLOCK_SIZE
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- line_req_valid  in  1  line request pending; held until line_req_ready is seen
- line_req_ready  out  1  one-cycle pulse: line_req_rdata valid this cycle
- line_req_addr  in  32  any byte address inside the requested line
- line_req_rdata  out  8*BLOCK_SIZE*NUM_BLOCKS  assembled line, word i at bits [i*8*BLOCK_SIZE +: 8*BLOCK_SIZE]
- mem_valid  out  1  word read request
- mem_ready  in  1  memory returns mem_rdata this cycle
- mem_addr  out  32  word-aligned read address
- mem_rdata  in  8*BLOCK_SIZE  read data, sampled when mem_valid && mem_ready

## Operation
- Derived: OFFSET_BITS = clog2(NUM_BLOCKS), BYTE_BITS = clog2(BLOCK_SIZE), base = line_req_addr with low OFFSET_BITS+BYTE_BITS bits cleared.
- States: IDLE, FETCH, RESP, DONE.
- IDLE: on line_req_valid, latch base, clear word counter, drive mem_addr = base, mem_valid = 1 → FETCH.
- FETCH: each cycle with mem_valid && mem_ready stores mem_rdata into word slot [counter], increments counter, advances mem_addr by BLOCK_SIZE, keeps mem_valid high. After the last word (counter = NUM_BLOCKS-1) transfers, mem_valid drops → RESP.
- RESP: line_req_ready = 1 for exactly one cycle, line_req_rdata holds the full line → DONE.
- DONE: one cycle, line_req_valid ignored (requester drops valid one cycle late) → IDLE.
- Abort: line_req_valid low during FETCH sets an abort flag; the outstanding word handshake still completes (mem_valid never drops mid-word). On that completion → IDLE, mem_valid 0, no ready pulse, no buffer update.
- Address wrap: mem_addr increments within 32 bits; a line at 0xFFFF_FFF0 fetches 0x...F0..FC without wrapping into the next line (counter bounds the fill).
- line_req_rdata holds its last value outside RESP; only RESP is meaningful.

## Timing
- Reset values: line_req_ready 0, mem_valid 0, mem_addr 0, line_req_rdata 0, state IDLE, abort 0, counter 0.
- Reset mid-fill: next edge returns to IDLE with mem_valid 0; partial line discarded.
- Request accepted at edge 0 → mem_valid high from cycle 1.
- Zero-wait memory (mem_ready tied high): words transfer cycles 1..NUM_BLOCKS, ready pulse cycle NUM_BLOCKS+1, back in IDLE at NUM_BLOCKS+3. Fill latency = NUM_BLOCKS + 1 + sum of memory wait cycles.
- New request earliest in IDLE; line_req_valid high in DONE is not a new request.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- ICACHE_LINE_FILL_BUF_EN defined: one-entry line buffer (line data, base, valid bit). Updated on every RESP from a memory fill. In IDLE, a request whose base matches a valid entry goes IDLE → RESP directly (ready pulse one cycle after acceptance, no memory traffic). Reset clears the valid bit; aborted fills never update it.
- Undefined: no buffer; every request performs a full memory fill.

## Structure
- Shared package icache_pkg: state enum (IDLE, FETCH, RESP, DONE), OFFSET_BITS/BYTE_BITS derivation functions, line-width localparam.
- One sub-module, icache_line_buf (tag compare + data storage), instantiated only under ICACHE_LINE_FILL_BUF_EN.

## Test plan
- Zero-wait memory, request 0x0000_1234 → mem_addr 0x1230, 0x1234, 0x1238, 0x123C on cycles 1-4; ready pulse cycle 5 with rdata {w3,w2,w1,w0}.
- mem_ready delayed 2 cycles per word → mem_addr stable while waiting, ready pulse at cycle 13, exactly one pulse.
- line_req_valid dropped after word 1 → word 2 handshake completes, mem_valid low next cycle, no ready pulse, next request fills from scratch.
- Reset asserted during word 2 wait → mem_valid 0 and state IDLE at next edge; all outputs at reset values.
- Request at 0xFFFF_FFF4 → addresses 0xFFFF_FFF0..FFFC only; fill ends after 4 words.
- With ICACHE_LINE_FILL_BUF_EN: fill 0x1230 then request 0x1238 → ready pulse cycle 1, mem_valid never asserted, same rdata; request 0x2000 → full memory fill.
